arp_responder: RTL and testbench

//  Sits directly downstream of the ARP frame receiver. Consumes decoded ARP frames (parallel

---
 rtl/arp_pkg.sv | 11 +
 rtl/stat_counter_sat.sv | 13 +
 rtl/arp_responder.sv | 124 ++++++++++++
 tb/tb_arp_responder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/arp_pkg.sv
// arp_pkg: shared ARP/Ethernet constants and responder state type.
package arp_pkg;
  localparam logic [15:0] ETH_TYPE_ARP     = 16'h0806;
  localparam logic [15:0] ARP_HTYPE_ETH    = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4   = 16'h0800;
  localparam logic [15:0] ARP_OPER_REQUEST = 16'd1;
  localparam logic [15:0] ARP_OPER_REPLY   = 16'd2;
  localparam logic [7:0]  ARP_HLEN_ETH     = 8'd6;
  localparam logic [7:0]  ARP_PLEN_IPV4    = 8'd4;
  typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/stat_counter_sat.sv
// stat_counter_sat: W-bit counter that increments on inc and sticks at all-ones.
module stat_counter_sat #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/arp_responder.sv
// arp_responder: validates decoded ARP frames, answers requests for local_ip and
// emits cache write requests for learned IP->MAC bindings.
module arp_responder
  import arp_pkg::*;
#(
  parameter bit CACHE_UPDATE_ENABLE = 1'b1,
  parameter int STAT_WIDTH          = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_frame_valid,
  output logic                  s_frame_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [47:0]           s_eth_src_mac,
  input  logic [15:0]           s_eth_type,
  input  logic [15:0]           s_arp_htype,
  input  logic [15:0]           s_arp_ptype,
  input  logic [15:0]           s_arp_oper,
  input  logic [7:0]            s_arp_hlen,
  input  logic [7:0]            s_arp_plen,
  input  logic [47:0]           s_arp_sha,
  input  logic [47:0]           s_arp_tha,
  input  logic [31:0]           s_arp_spa,
  input  logic [31:0]           s_arp_tpa,
  input  logic [47:0]           local_mac,
  input  logic [31:0]           local_ip,
  output logic                  m_frame_valid,
  input  logic                  m_frame_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,
  output logic [15:0]           m_arp_htype,
  output logic [15:0]           m_arp_ptype,
  output logic [15:0]           m_arp_oper,
  output logic [7:0]            m_arp_hlen,
  output logic [7:0]            m_arp_plen,
  output logic [47:0]           m_arp_sha,
  output logic [47:0]           m_arp_tha,
  output logic [31:0]           m_arp_spa,
  output logic [31:0]           m_arp_tpa,
  output logic                  m_cache_wr_valid,
  input  logic                  m_cache_wr_ready,
  output logic [31:0]           m_cache_wr_ip,
  output logic [47:0]           m_cache_wr_mac,
  output logic                  busy,
  output logic [STAT_WIDTH-1:0] stat_rx_count,
  output logic [STAT_WIDTH-1:0] stat_reply_count,
  output logic [STAT_WIDTH-1:0] stat_drop_count
);
  state_t state, state_n;
  logic accept, fmt_ok, grat, do_reply, do_cache, reply_n, cache_n;
  logic unused_rx;
  assign unused_rx = ^{s_eth_dest_mac, s_eth_src_mac, s_eth_type, s_arp_tha};
  assign accept = s_frame_valid && s_frame_ready;
  assign busy = (state == BUSY);
  // A zero sender IP can never be learned, so such frames are dropped outright.
  always_comb begin
    fmt_ok = s_arp_htype == ARP_HTYPE_ETH && s_arp_ptype == ARP_PTYPE_IPV4 &&
             s_arp_hlen == ARP_HLEN_ETH && s_arp_plen == ARP_PLEN_IPV4;
    grat = s_arp_spa == s_arp_tpa;
    do_reply = fmt_ok && s_arp_oper == ARP_OPER_REQUEST && !grat && local_ip != '0 &&
               s_arp_tpa == local_ip && s_arp_spa != '0;
    do_cache = fmt_ok && s_arp_spa != '0 &&
               (do_reply || (s_arp_oper == ARP_OPER_REQUEST && grat) || s_arp_oper == ARP_OPER_REPLY);
  end
  always_comb begin
    reply_n = m_frame_valid ? !m_frame_ready : accept && do_reply;
    cache_n = m_cache_wr_valid ? !m_cache_wr_ready : accept && do_cache && CACHE_UPDATE_ENABLE;
    state_n = (reply_n || cache_n) ? BUSY : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state            <= IDLE;
      s_frame_ready    <= 1'b0;
      m_frame_valid    <= 1'b0;
      m_cache_wr_valid <= 1'b0;
      m_eth_dest_mac   <= '0;
      m_eth_src_mac    <= '0;
      m_eth_type       <= '0;
      m_arp_htype      <= '0;
      m_arp_ptype      <= '0;
      m_arp_oper       <= '0;
      m_arp_hlen       <= '0;
      m_arp_plen       <= '0;
      m_arp_sha        <= '0;
      m_arp_tha        <= '0;
      m_arp_spa        <= '0;
      m_arp_tpa        <= '0;
      m_cache_wr_ip    <= '0;
      m_cache_wr_mac   <= '0;
    end else begin
      state            <= state_n;
      s_frame_ready    <= state_n == IDLE;
      m_frame_valid    <= reply_n;
      m_cache_wr_valid <= cache_n;
      if (accept && do_reply) begin
        m_eth_dest_mac <= s_arp_sha;
        m_eth_src_mac  <= local_mac;
        m_eth_type     <= ETH_TYPE_ARP;
        m_arp_htype    <= ARP_HTYPE_ETH;
        m_arp_ptype    <= ARP_PTYPE_IPV4;
        m_arp_oper     <= ARP_OPER_REPLY;
        m_arp_hlen     <= ARP_HLEN_ETH;
        m_arp_plen     <= ARP_PLEN_IPV4;
        m_arp_sha      <= local_mac;
        m_arp_tha      <= s_arp_sha;
        m_arp_spa      <= local_ip;
        m_arp_tpa      <= s_arp_spa;
      end
      if (accept && do_cache) begin
        m_cache_wr_ip  <= s_arp_spa;
        m_cache_wr_mac <= s_arp_sha;
      end
    end
  stat_counter_sat #(.W(STAT_WIDTH)) u_rx (
    .clk(clk), .rst(rst), .inc(accept), .count(stat_rx_count)
  );
  stat_counter_sat #(.W(STAT_WIDTH)) u_reply (
    .clk(clk), .rst(rst), .inc(m_frame_valid && m_frame_ready), .count(stat_reply_count)
  );
  stat_counter_sat #(.W(STAT_WIDTH)) u_drop (
    .clk(clk), .rst(rst), .inc(accept && !do_cache), .count(stat_drop_count)
  );
endmodule

// File: tb/tb_arp_responder.sv
// tb_arp_responder: table-driven frames with reply/cache scoreboards plus
// hand-written backpressure, reset and saturation sequences.
module tb_arp_responder;
  localparam logic [47:0] LMAC = 48'h02_00_00_00_00_01;
  typedef struct {
    logic [15:0] htype, ptype, oper;
    logic [7:0]  hlen, plen;
    logic [47:0] sha;
    logic [31:0] spa, tpa, lip;
    logic        rep, cac;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic s_frame_valid = 1'b0, s_frame_ready;
  logic [47:0] s_eth_dest_mac = '1, s_eth_src_mac = '0, s_arp_sha = '0, s_arp_tha = '0;
  logic [15:0] s_eth_type = 16'h0806, s_arp_htype = '0, s_arp_ptype = '0, s_arp_oper = '0;
  logic [7:0]  s_arp_hlen = '0, s_arp_plen = '0;
  logic [31:0] s_arp_spa = '0, s_arp_tpa = '0, local_ip = '0;
  logic [47:0] local_mac = LMAC;
  logic m_frame_valid, m_frame_ready = 1'b1, m_cache_wr_valid, m_cache_wr_ready = 1'b1, busy;
  logic [47:0] m_eth_dest_mac, m_eth_src_mac, m_arp_sha, m_arp_tha, m_cache_wr_mac;
  logic [15:0] m_eth_type, m_arp_htype, m_arp_ptype, m_arp_oper;
  logic [7:0]  m_arp_hlen, m_arp_plen;
  logic [31:0] m_arp_spa, m_arp_tpa, m_cache_wr_ip;
  logic [15:0] stat_rx_count, stat_reply_count, stat_drop_count;
  logic [335:0] rep_q[$];
  logic [79:0]  cac_q[$];
  int n_checks = 0, n_fail = 0;
  int exp_rx = 0, exp_reply = 0, exp_drop = 0;
  vec_t v[13];

  arp_responder dut (
    .clk(clk), .rst(rst), .s_frame_valid(s_frame_valid), .s_frame_ready(s_frame_ready),
    .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac), .s_eth_type(s_eth_type),
    .s_arp_htype(s_arp_htype), .s_arp_ptype(s_arp_ptype), .s_arp_oper(s_arp_oper),
    .s_arp_hlen(s_arp_hlen), .s_arp_plen(s_arp_plen), .s_arp_sha(s_arp_sha),
    .s_arp_tha(s_arp_tha), .s_arp_spa(s_arp_spa), .s_arp_tpa(s_arp_tpa),
    .local_mac(local_mac), .local_ip(local_ip),
    .m_frame_valid(m_frame_valid), .m_frame_ready(m_frame_ready),
    .m_eth_dest_mac(m_eth_dest_mac), .m_eth_src_mac(m_eth_src_mac), .m_eth_type(m_eth_type),
    .m_arp_htype(m_arp_htype), .m_arp_ptype(m_arp_ptype), .m_arp_oper(m_arp_oper),
    .m_arp_hlen(m_arp_hlen), .m_arp_plen(m_arp_plen), .m_arp_sha(m_arp_sha),
    .m_arp_tha(m_arp_tha), .m_arp_spa(m_arp_spa), .m_arp_tpa(m_arp_tpa),
    .m_cache_wr_valid(m_cache_wr_valid), .m_cache_wr_ready(m_cache_wr_ready),
    .m_cache_wr_ip(m_cache_wr_ip), .m_cache_wr_mac(m_cache_wr_mac), .busy(busy),
    .stat_rx_count(stat_rx_count), .stat_reply_count(stat_reply_count),
    .stat_drop_count(stat_drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [335:0] act, input logic [335:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [335:0] reply_model(input vec_t f);
    return {f.sha, LMAC, 16'h0806, 16'h0001, 16'h0800, 8'd6, 8'd4, 16'h0002,
            LMAC, f.lip, f.sha, f.spa};
  endfunction

  function automatic logic [335:0] reply_dut();
    return {m_eth_dest_mac, m_eth_src_mac, m_eth_type, m_arp_htype, m_arp_ptype,
            m_arp_hlen, m_arp_plen, m_arp_oper, m_arp_sha, m_arp_spa, m_arp_tha, m_arp_tpa};
  endfunction

  always @(negedge clk)
    if (!rst) begin
      if (m_frame_valid && m_frame_ready) begin
        if (rep_q.size() == 0) check("unexpected_reply", 336'd1, 336'd0);
        else check("reply_fields", reply_dut(), rep_q.pop_front());
      end
      if (m_cache_wr_valid && m_cache_wr_ready) begin
        if (cac_q.size() == 0) check("unexpected_cache_wr", 336'd1, 336'd0);
        else check("cache_wr", {256'd0, m_cache_wr_ip, m_cache_wr_mac}, {256'd0, cac_q.pop_front()});
      end
    end

  // Drives one frame for exactly one accepting edge; returns #1 after that edge.
  task automatic drive_frame(input vec_t f);
    @(negedge clk);
    s_arp_htype = f.htype; s_arp_ptype = f.ptype; s_arp_oper = f.oper;
    s_arp_hlen = f.hlen; s_arp_plen = f.plen; s_arp_sha = f.sha; s_eth_src_mac = f.sha;
    s_arp_spa = f.spa; s_arp_tpa = f.tpa; local_ip = f.lip;
    s_frame_valid = 1'b1;
    if (f.rep) begin rep_q.push_back(reply_model(f)); exp_reply++; end
    if (f.cac) cac_q.push_back({f.spa, f.sha});
    exp_rx++;
    if (!f.rep && !f.cac) exp_drop++;
    @(posedge clk);
    #1 s_frame_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i = 0;
    while (!s_frame_ready && i < 50) begin @(negedge clk); i++; end
    check("idle_timeout", {335'd0, s_frame_ready}, 336'd1);
  endtask

  task automatic check_stats(input string tag);
    @(negedge clk);
    check({tag, "_rx"}, {320'd0, stat_rx_count}, 336'(exp_rx));
    check({tag, "_reply"}, {320'd0, stat_reply_count}, 336'(exp_reply));
    check({tag, "_drop"}, {320'd0, stat_drop_count}, 336'(exp_drop));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    v[0]  = '{16'h0001, 16'h0800, 16'd1, 8'd6,  8'd4, 48'hAABBCCDDEEFF, 32'hC0A80101, 32'hC0A80180, 32'hC0A80180, 1'b1, 1'b1};
    v[1]  = '{16'h0001, 16'h0800, 16'd1, 8'd6,  8'd4, 48'hAABBCCDDEEFF, 32'hC0A80101, 32'hC0A80199, 32'hC0A80180, 1'b0, 1'b0};
    v[2]  = '{16'h0001, 16'h0800, 16'd1, 8'd8,  8'd4, 48'hAABBCCDDEEFF, 32'hC0A80101, 32'hC0A80180, 32'hC0A80180, 1'b0, 1'b0};
    v[3]  = '{16'h0001, 16'h86DD, 16'd1, 8'd6,  8'd4, 48'hAABBCCDDEEFF, 32'hC0A80101, 32'hC0A80180, 32'hC0A80180, 1'b0, 1'b0};
    v[4]  = '{16'h0001, 16'h0800, 16'd2, 8'd6,  8'd4, 48'h112233445566, 32'h0A000001, 32'hC0A80180, 32'hC0A80180, 1'b0, 1'b1};
    v[5]  = '{16'h0001, 16'h0800, 16'd1, 8'd6,  8'd4, 48'hAABBCCDDEEFF, 32'hC0A80101, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
    v[6]  = '{16'h0001, 16'h0800, 16'd1, 8'd6,  8'd4, 48'h0A0B0C0D0E0F, 32'hC0A80105, 32'hC0A80105, 32'hC0A80180, 1'b0, 1'b1};
    v[7]  = '{16'h0001, 16'h0800, 16'd3, 8'd6,  8'd4, 48'hAABBCCDDEEFF, 32'hC0A80101, 32'hC0A80180, 32'hC0A80180, 1'b0, 1'b0};
    v[8]  = '{16'h0001, 16'h0800, 16'd2, 8'd6,  8'd4, 48'h112233445566, 32'h00000000, 32'hC0A80180, 32'hC0A80180, 1'b0, 1'b0};
    v[9]  = '{16'h0001, 16'h0800, 16'd1, 8'd6,  8'd4, 48'hAABBCCDDEEFF, 32'h00000000, 32'hC0A80180, 32'hC0A80180, 1'b0, 1'b0};
    v[10] = '{16'h0006, 16'h0800, 16'd1, 8'd6,  8'd4, 48'hAABBCCDDEEFF, 32'hC0A80101, 32'hC0A80180, 32'hC0A80180, 1'b0, 1'b0};
    v[11] = '{16'h0001, 16'h0800, 16'd1, 8'd6,  8'd4, 48'h001122334455, 32'hC0A801FE, 32'hC0A80180, 32'hC0A80180, 1'b1, 1'b1};
    v[12] = '{16'h0001, 16'h0800, 16'd1, 8'd6, 8'd16, 48'hAABBCCDDEEFF, 32'hC0A80101, 32'hC0A80180, 32'hC0A80180, 1'b0, 1'b0};

    #12;
    check("reset_outputs", {330'd0, s_frame_ready, m_frame_valid, m_cache_wr_valid, busy, 2'b00}, 336'd0);
    check("reset_data", reply_dut(), 336'd0);
    check_stats("reset");
    rst = 1'b0;
    check("ready_before_edge", {335'd0, s_frame_ready}, 336'd0);
    @(posedge clk); #1;
    check("ready_after_edge", {335'd0, s_frame_ready}, 336'd1);

    foreach (v[i]) begin
      drive_frame(v[i]);
      check($sformatf("v%0d_outputs_n1", i), {333'd0, m_frame_valid, m_cache_wr_valid, s_frame_ready},
            {333'd0, v[i].rep, v[i].cac, !(v[i].rep || v[i].cac)});
      wait_idle();
    end
    check_stats("table");

    // Reply held off for 10 cycles while the cache write completes immediately.
    @(posedge clk); #1 m_frame_ready = 1'b0;
    drive_frame(v[0]);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d_reply", i), {reply_dut(), 335'd0, m_frame_valid} >> 335'd0 == 0 ? 336'd0 : reply_dut(), reply_model(v[0]));
      check($sformatf("hold%0d_flags", i), {333'd0, m_frame_valid, m_cache_wr_valid, s_frame_ready},
            {333'd0, 1'b1, i == 0, 1'b0});
    end
    @(posedge clk); #1 m_frame_ready = 1'b1;
    @(negedge clk);
    check("hold_ready_low_at_hs", {335'd0, s_frame_ready}, 336'd0);
    @(negedge clk);
    check("after_hs", {334'd0, m_frame_valid, s_frame_ready}, {334'd0, 1'b0, 1'b1});
    check_stats("hold");

    // Asynchronous reset with a reply still pending.
    @(posedge clk); #1 m_frame_ready = 1'b0;
    drive_frame(v[0]);
    @(negedge clk);
    check("pending_before_rst", {335'd0, m_frame_valid}, 336'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_flags", {332'd0, m_frame_valid, m_cache_wr_valid, busy, s_frame_ready}, 336'd0);
    check("async_rst_data", reply_dut(), 336'd0);
    rep_q.delete(); cac_q.delete();
    exp_rx = 0; exp_reply = 0; exp_drop = 0;
    check_stats("async_rst");
    m_frame_ready = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", {335'd0, s_frame_ready}, 336'd1);

    // Continuous malformed frames to saturate rx and drop counters.
    @(negedge clk);
    s_arp_htype = 16'h0001; s_arp_ptype = 16'h0800; s_arp_oper = 16'd1;
    s_arp_hlen = 8'd8; s_arp_plen = 8'd4; s_frame_valid = 1'b1;
    repeat (65540) @(posedge clk);
    #1 s_frame_valid = 1'b0;
    @(negedge clk);
    check("sat_drop", {320'd0, stat_drop_count}, {320'd0, 16'hFFFF});
    check("sat_rx", {320'd0, stat_rx_count}, {320'd0, 16'hFFFF});
    check("sat_reply", {320'd0, stat_reply_count}, 336'd0);
    check("sat_no_outputs", {334'd0, m_frame_valid, m_cache_wr_valid}, 336'd0);

    repeat (3) @(negedge clk);
    check("reply_q_empty", 336'(rep_q.size()), 336'd0);
    check("cache_q_empty", 336'(cac_q.size()), 336'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
